// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the MEM stage and its load-alignment helper.
//   - LOP_* : load-op encoding carried from EX (others decode as LW)
//   - ms_state_t : MEM stage occupancy (empty / waiting on data / complete)
package mycpu_pkg;

  localparam logic [2:0] LOP_LW  = 3'd0;
  localparam logic [2:0] LOP_LB  = 3'd1;
  localparam logic [2:0] LOP_LBU = 3'd2;
  localparam logic [2:0] LOP_LH  = 3'd3;
  localparam logic [2:0] LOP_LHU = 3'd4;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// EX -> MEM pipeline handshake bus.
//   master (EX side) : drives es_to_ms_valid and the payload, samples ms_allowin
//   slave  (MEM side): samples es_to_ms_valid and the payload, drives ms_allowin
// Payload: es_mem_req, es_load_op[2:0], es_addr_lo[2:0], es_gr_we, es_dest[4:0],
//          es_result[XLEN-1:0], es_pc[XLEN-1:0]
interface mem_stage_hs_if #(
  parameter int XLEN = 32
);

  logic            es_to_ms_valid;
  logic            ms_allowin;
  logic            es_mem_req;
  logic [2:0]      es_load_op;
  logic [2:0]      es_addr_lo;
  logic            es_gr_we;
  logic [4:0]      es_dest;
  logic [XLEN-1:0] es_result;
  logic [XLEN-1:0] es_pc;

  modport master (
    output es_to_ms_valid, es_mem_req, es_load_op, es_addr_lo,
           es_gr_we, es_dest, es_result, es_pc,
    input  ms_allowin
  );

  modport slave (
    input  es_to_ms_valid, es_mem_req, es_load_op, es_addr_lo,
           es_gr_we, es_dest, es_result, es_pc,
    output ms_allowin
  );

endinterface

// File: rtl/mem_stage_hs_load_align.sv
// load_align: combinational sub-word extraction and extension of a read word.
//   rdata[XLEN-1:0] in  : raw data-SRAM / cache word
//   addr_lo[2:0]    in  : byte address within the word (bit 2 only used when XLEN=64)
//   load_op[2:0]    in  : LOP_* encoding; unknown codes behave as LW
//   result[XLEN-1:0] out: aligned, sign/zero-extended value
// Also used by the cache refill path, so it keeps no state.
module load_align
  import mycpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      load_op,
  output logic [XLEN-1:0] result
);

  logic [2:0]      byte_off;
  logic [1:0]      half_off;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
    logic signed [7:0] s;
    s = v;
    if (sgn) return XLEN'(s);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
    logic signed [15:0] s;
    s = v;
    if (sgn) return XLEN'(s);
    return XLEN'(v);
  endfunction

  // Word loads always take the low 32 bits sign-extended (a no-op at XLEN=32).
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  assign byte_off = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
  assign half_off = (XLEN == 64) ? addr_lo[2:1] : {1'b0, addr_lo[1]};
  assign byte_sh  = rdata >> {byte_off, 3'b000};
  assign half_sh  = rdata >> {half_off, 4'b0000};

  always_comb begin
    result = ext32(rdata[31:0]);
    case (load_op)
      LOP_LB:  result = ext8(byte_sh[7:0], 1'b1);
      LOP_LBU: result = ext8(byte_sh[7:0], 1'b0);
      LOP_LH:  result = ext16(half_sh[15:0], 1'b1);
      LOP_LHU: result = ext16(half_sh[15:0], 1'b0);
      default: result = ext32(rdata[31:0]);
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage with a data_ok load-response handshake.
//   clk, reset (async, active-low)
//   ws_allowin in        : WB can take a payload
//   flush in             : cancels the MEM contents this cycle
//   es_bus (slave)       : EX -> MEM valid/allowin handshake and payload
//   data_sram_data_ok/rdata in : in-order read responses, one per request
//   ms_to_ws_valid, ms_gr_we, ms_dest, ms_final_result, ms_pc out : WB payload
//   ms_fwd_we/dest/data/pending out : forwarding bus to ID; pending means the
//                                     destination is known but the load data is not
// Optional build macro MS_STALL_CNT_EN adds ms_stall_cycles[31:0], a free-running
// count of cycles spent waiting on data or blocked by WB (not cleared by flush).
module mem_stage_hs
  import mycpu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ws_allowin,
  input  logic              flush,
  mem_stage_hs_if.slave     es_bus,
  input  logic              data_sram_data_ok,
  input  logic [XLEN-1:0]   data_sram_rdata,
  output logic              ms_to_ws_valid,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic [XLEN-1:0]   ms_final_result,
  output logic [XLEN-1:0]   ms_pc,
  output logic              ms_fwd_we,
  output logic [4:0]        ms_fwd_dest,
  output logic [XLEN-1:0]   ms_fwd_data,
  output logic              ms_fwd_pending
`ifdef MS_STALL_CNT_EN
  , output logic [31:0]     ms_stall_cycles
`endif
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  ms_state_t        state_p1;
  logic [CNT_W-1:0] discard_cnt;
  logic             vld_p1;
  logic             gr_we_p1;
  logic             mem_req_p1;
  logic [4:0]       dest_p1;
  logic [2:0]       load_op_p1;
  logic [2:0]       addr_lo_p1;
  logic [XLEN-1:0]  result_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [XLEN-1:0]  buffer_p1;
  logic [XLEN-1:0]  aligned;
  logic [XLEN-1:0]  final_result;
  logic             accept;
  logic             resp_discard;
  logic             resp_take;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (data_sram_rdata),
    .addr_lo (addr_lo_p1),
    .load_op (load_op_p1),
    .result  (aligned)
  );

  assign vld_p1            = (state_p1 != MS_EMPTY);
  assign es_bus.ms_allowin = (state_p1 == MS_EMPTY) | ((state_p1 == MS_READY) & ws_allowin);
  assign accept            = es_bus.ms_allowin & es_bus.es_to_ms_valid & ~flush;
  // Responses owed to flushed loads arrive first (in order), so they win over WAIT.
  assign resp_discard      = data_sram_data_ok & (discard_cnt != '0);
  assign resp_take         = data_sram_data_ok & ~resp_discard & (state_p1 == MS_WAIT);

  // ---- EX -> MEM stage register / response capture ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1    <= MS_EMPTY;
      discard_cnt <= '0;
      gr_we_p1    <= 1'b0;
      mem_req_p1  <= 1'b0;
      dest_p1     <= '0;
      load_op_p1  <= '0;
      addr_lo_p1  <= '0;
      result_p1   <= '0;
      pc_p1       <= '0;
      buffer_p1   <= '0;
    end else if (flush) begin
      state_p1 <= MS_EMPTY;
      // A response in the flush cycle retires the waiting load itself, so only
      // an unanswered WAIT leaves a stale response to swallow later.
      if (resp_discard)
        discard_cnt <= discard_cnt - 1'b1;
      else if ((state_p1 == MS_WAIT) && !data_sram_data_ok && (discard_cnt != CNT_MAX))
        discard_cnt <= discard_cnt + 1'b1;
    end else begin
      if (resp_discard)
        discard_cnt <= discard_cnt - 1'b1;
      if (accept) begin
        gr_we_p1   <= es_bus.es_gr_we;
        mem_req_p1 <= es_bus.es_mem_req;
        dest_p1    <= es_bus.es_dest;
        load_op_p1 <= es_bus.es_load_op;
        addr_lo_p1 <= es_bus.es_addr_lo;
        result_p1  <= es_bus.es_result;
        pc_p1      <= es_bus.es_pc;
        state_p1   <= es_bus.es_mem_req ? MS_WAIT : MS_READY;
      end else if (resp_take) begin
        buffer_p1 <= aligned;
        state_p1  <= MS_READY;
      end else if ((state_p1 == MS_READY) && ws_allowin) begin
        state_p1 <= MS_EMPTY;
      end
    end
  end

  // ---- MEM -> WB / forwarding outputs ----
  assign final_result    = mem_req_p1 ? buffer_p1 : result_p1;
  assign ms_to_ws_valid  = (state_p1 == MS_READY);
  assign ms_gr_we        = gr_we_p1;
  assign ms_dest         = dest_p1;
  assign ms_final_result = final_result;
  assign ms_pc           = pc_p1;
  assign ms_fwd_we       = vld_p1 & gr_we_p1;
  assign ms_fwd_dest     = dest_p1;
  assign ms_fwd_data     = final_result;
  assign ms_fwd_pending  = (state_p1 == MS_WAIT) & gr_we_p1;

`ifdef MS_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ms_stall_cycles <= '0;
    else if ((state_p1 == MS_WAIT) || ((state_p1 == MS_READY) && !ws_allowin))
      ms_stall_cycles <= ms_stall_cycles + 32'd1;
  end
`endif

  // A response with no flushed load to discard and no load waiting has no owner.
  a_orphan_data_ok: assert property (@(posedge clk) disable iff (!reset)
    !(data_sram_data_ok && (discard_cnt == '0) && (state_p1 != MS_WAIT)));

endmodule

// File: tb/tb_mem_stage_hs.sv
`timescale 1ns/1ps
module tb_mem_stage_hs;
  import mycpu_pkg::*;

  localparam int XLEN = 32;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ws_allowin = 1'b0;
  logic        flush = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        ms_to_ws_valid, ms_gr_we, ms_fwd_we, ms_fwd_pending;
  logic [4:0]  ms_dest, ms_fwd_dest;
  logic [31:0] ms_final_result, ms_pc, ms_fwd_data;
`ifdef MS_STALL_CNT_EN
  logic [31:0] ms_stall_cycles;
  logic [31:0] stall_base;
`endif

  mem_stage_hs_if #(.XLEN(XLEN)) es_bus ();

  mem_stage_hs #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .flush             (flush),
    .es_bus            (es_bus.slave),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_final_result   (ms_final_result),
    .ms_pc             (ms_pc),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_dest       (ms_fwd_dest),
    .ms_fwd_data       (ms_fwd_data),
    .ms_fwd_pending    (ms_fwd_pending)
`ifdef MS_STALL_CNT_EN
    , .ms_stall_cycles (ms_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_es(input logic v, input logic req, input logic [2:0] op,
                          input logic [2:0] a, input logic we, input logic [4:0] d,
                          input logic [31:0] res, input logic [31:0] pc);
    es_bus.es_to_ms_valid = v;
    es_bus.es_mem_req     = req;
    es_bus.es_load_op     = op;
    es_bus.es_addr_lo     = a;
    es_bus.es_gr_we       = we;
    es_bus.es_dest        = d;
    es_bus.es_result      = res;
    es_bus.es_pc          = pc;
  endtask

  task automatic es_idle();
    drive_es(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Spec-level meaning of each load op, plain arithmetic on the byte lane.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [2:0] a,
                                           input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    h = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? (b - 256) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h - 65536) : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  // Accept one load, return its data 'lat' cycles later, check WAIT and WB.
  task automatic do_load(input string nm, input logic [2:0] op, input logic [2:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] exp);
    ws_allowin = 1'b1;
    drive_es(1'b1, 1'b1, op, a, 1'b1, 5'd8, 32'h0BAD_0BAD, 32'h0040_0100);
    mid();
    chk({nm, ".allowin"}, es_bus.ms_allowin, 1'b1);
    tick();
    es_idle();
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) begin
        data_ok = 1'b1;
        rdata   = d;
      end
      mid();
      chk({nm, ".pending"}, ms_fwd_pending, 1'b1);
      chk({nm, ".wait_valid"}, ms_to_ws_valid, 1'b0);
      tick();
      data_ok = 1'b0;
    end
    mid();
    chk({nm, ".valid"}, ms_to_ws_valid, 1'b1);
    chk({nm, ".result"}, ms_final_result, exp);
    chk({nm, ".pending_done"}, ms_fwd_pending, 1'b0);
    tick();
    mid();
    chk({nm, ".drained"}, ms_to_ws_valid, 1'b0);
    tick();
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [2:0]  a;
    logic [31:0] d;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  // Reference model state for the random phase.
  logic        m_valid, m_is_load, m_have, m_gr_we;
  logic [4:0]  m_dest;
  logic [2:0]  m_op, m_addr;
  logic [31:0] m_result, m_pc, m_data;
  bit          stale_q[$];
  logic        waiting, ready, exp_allowin, popped_live, front;
  int          stale_cnt;
  logic        r_valid, r_req, r_we;
  logic [2:0]  r_op, r_a;
  logic [4:0]  r_d;
  logic [31:0] r_res, r_pc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{"lw",      3'd0, 3'd0, 32'h8765_4321, 1, 32'h8765_4321};
    tbl[1]  = '{"lb_a0",   3'd1, 3'd0, 32'h1234_5680, 2, 32'hFFFF_FF80};
    tbl[2]  = '{"lb_a3",   3'd1, 3'd3, 32'h80FF_0000, 3, 32'hFFFF_FF80};
    tbl[3]  = '{"lbu_a3",  3'd2, 3'd3, 32'h80FF_0000, 3, 32'h0000_0080};
    tbl[4]  = '{"lb_a1",   3'd1, 3'd1, 32'h0000_7F00, 1, 32'h0000_007F};
    tbl[5]  = '{"lbu_a2",  3'd2, 3'd2, 32'h00AB_0000, 2, 32'h0000_00AB};
    tbl[6]  = '{"lh_a2",   3'd3, 3'd2, 32'h7FFF_1234, 1, 32'h0000_7FFF};
    tbl[7]  = '{"lh_a0",   3'd3, 3'd0, 32'h0000_8001, 4, 32'hFFFF_8001};
    tbl[8]  = '{"lhu_a0",  3'd4, 3'd0, 32'h0000_8001, 1, 32'h0000_8001};
    tbl[9]  = '{"lhu_a2",  3'd4, 3'd2, 32'hF00D_0000, 2, 32'h0000_F00D};
    tbl[10] = '{"op7_lw",  3'd7, 3'd1, 32'hCAFE_BABE, 1, 32'hCAFE_BABE};
    tbl[11] = '{"lb_a4",   3'd1, 3'd4, 32'h0000_00FE, 1, 32'hFFFF_FFFE};

    es_idle();
    #2;
    chk("rst.to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst.gr_we", ms_gr_we, 1'b0);
    chk("rst.fwd_we", ms_fwd_we, 1'b0);
    chk("rst.pending", ms_fwd_pending, 1'b0);
    chk("rst.result", ms_final_result, 32'd0);
    chk("rst.pc", ms_pc, 32'd0);
    chk("rst.dest", ms_dest, 5'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // ALU op straight through
    ws_allowin = 1'b1;
    drive_es(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0000);
    mid();
    chk("alu.allowin", es_bus.ms_allowin, 1'b1);
    chk("alu.pending0", ms_fwd_pending, 1'b0);
    tick();
    es_idle();
    mid();
    chk("alu.valid", ms_to_ws_valid, 1'b1);
    chk("alu.result", ms_final_result, 32'h1234_5678);
    chk("alu.fwd_data", ms_fwd_data, 32'h1234_5678);
    chk("alu.fwd_we", ms_fwd_we, 1'b1);
    chk("alu.fwd_dest", ms_fwd_dest, 5'd5);
    chk("alu.pc", ms_pc, 32'hBFC0_0000);
    chk("alu.pending1", ms_fwd_pending, 1'b0);
    tick();
    mid();
    chk("alu.drained", ms_to_ws_valid, 1'b0);
    tick();

    for (int i = 0; i < 12; i++)
      do_load(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].exp);

    // LH held by WB for 4 cycles, then back-to-back ALU accept
    ws_allowin = 1'b1;
    drive_es(1'b1, 1'b1, 3'd3, 3'd2, 1'b1, 5'd3, 32'd0, 32'h100);
    tick();
    drive_es(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 5'd9, 32'hAAAA_5555, 32'h104);
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 32'h7FFF_1234;
    mid();
    chk("hold.pending", ms_fwd_pending, 1'b1);
    chk("hold.allowin_wait", es_bus.ms_allowin, 1'b0);
    tick();
    data_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("hold.valid", ms_to_ws_valid, 1'b1);
      chk("hold.result", ms_final_result, 32'h0000_7FFF);
      chk("hold.allowin", es_bus.ms_allowin, 1'b0);
      tick();
    end
    ws_allowin = 1'b1;
    mid();
    chk("hold.allowin_rel", es_bus.ms_allowin, 1'b1);
    chk("hold.result_rel", ms_final_result, 32'h0000_7FFF);
    tick();
    es_idle();
    mid();
    chk("b2b.valid", ms_to_ws_valid, 1'b1);
    chk("b2b.result", ms_final_result, 32'hAAAA_5555);
    chk("b2b.dest", ms_dest, 5'd9);
    tick();

    // Flush a waiting LW; its late response must be discarded
    drive_es(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd4, 32'd0, 32'h200);
    tick();
    es_idle();
    flush = 1'b1;
    mid();
    chk("fl.pending", ms_fwd_pending, 1'b1);
    tick();
    flush = 1'b0;
    drive_es(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd6, 32'd0, 32'h204);
    mid();
    chk("fl.allowin", es_bus.ms_allowin, 1'b1);
    chk("fl.empty", ms_to_ws_valid, 1'b0);
    tick();
    es_idle();
    data_ok = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    mid();
    chk("fl.stale_valid", ms_to_ws_valid, 1'b0);
    tick();
    rdata = 32'h1111_2222;
    mid();
    chk("fl.after_stale_valid", ms_to_ws_valid, 1'b0);
    chk("fl.after_stale_pend", ms_fwd_pending, 1'b1);
    tick();
    data_ok = 1'b0;
    mid();
    chk("fl.valid", ms_to_ws_valid, 1'b1);
    chk("fl.result", ms_final_result, 32'h1111_2222);
    chk("fl.pc", ms_pc, 32'h204);
    tick();
    mid();
    chk("fl.drained", ms_to_ws_valid, 1'b0);
    tick();

    // No accept in a flush cycle
    drive_es(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 5'd7, 32'h7777_7777, 32'h300);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    es_idle();
    mid();
    chk("flacc.valid", ms_to_ws_valid, 1'b0);
    chk("flacc.fwd_we", ms_fwd_we, 1'b0);
    tick();

    // flush and data_ok together in WAIT: nothing left to discard
    drive_es(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd4, 32'd0, 32'h400);
    tick();
    es_idle();
    flush   = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'h5555_5555;
    tick();
    flush   = 1'b0;
    data_ok = 1'b0;
    do_load("flok", 3'd0, 3'd0, 32'h0123_4567, 2, 32'h0123_4567);

    // Discard counter saturates at MAX_OUTSTANDING
    for (int r = 0; r < 3; r++) begin
      drive_es(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd2, 32'd0, 32'h500);
      tick();
      es_idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    for (int r = 0; r < MAXO; r++) begin
      data_ok = 1'b1;
      rdata   = 32'hEEEE_0000 + r;
      mid();
      chk("sat.no_valid", ms_to_ws_valid, 1'b0);
      tick();
    end
    data_ok = 1'b0;
    do_load("sat", 3'd2, 3'd1, 32'h0000_AB00, 1, 32'h0000_00AB);

    // Reset asserted mid-WAIT
    ws_allowin = 1'b1;
    drive_es(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 5'd12, 32'd0, 32'h600);
    mid();
`ifdef MS_STALL_CNT_EN
    stall_base = ms_stall_cycles;
`endif
    tick();
    es_idle();
    for (int k = 0; k < 5; k++) tick();
    mid();
    chk("rw.pending", ms_fwd_pending, 1'b1);
`ifdef MS_STALL_CNT_EN
    chk("rw.stall_cycles", ms_stall_cycles - stall_base, 32'd5);
`endif
    #1;
    reset = 1'b0;
    #1;
    chk("rw.pending0", ms_fwd_pending, 1'b0);
    chk("rw.fwd_we0", ms_fwd_we, 1'b0);
    chk("rw.valid0", ms_to_ws_valid, 1'b0);
    chk("rw.result0", ms_final_result, 32'd0);
    chk("rw.pc0", ms_pc, 32'd0);
    chk("rw.dest0", ms_dest, 5'd0);
    chk("rw.gr_we0", ms_gr_we, 1'b0);
`ifdef MS_STALL_CNT_EN
    chk("rw.stall0", ms_stall_cycles, 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic against the reference model
    m_valid = 1'b0; m_is_load = 1'b0; m_have = 1'b0; m_gr_we = 1'b0;
    m_dest = '0; m_op = '0; m_addr = '0; m_result = '0; m_pc = '0; m_data = '0;
    stale_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      waiting     = m_valid & m_is_load & ~m_have;
      ready       = m_valid & ~waiting;
      stale_cnt   = 0;
      foreach (stale_q[j]) if (stale_q[j]) stale_cnt++;

      r_valid = ($urandom_range(0, 99) < 50);
      r_req   = $urandom_range(0, 1);
      r_op    = 3'($urandom_range(0, 7));
      r_a     = 3'($urandom_range(0, 7));
      r_we    = $urandom_range(0, 1);
      r_d     = 5'($urandom_range(0, 31));
      r_res   = $urandom;
      r_pc    = $urandom;
      drive_es(r_valid, r_req, r_op, r_a, r_we, r_d, r_res, r_pc);
      ws_allowin = ($urandom_range(0, 99) < 70);
      data_ok    = (stale_q.size() > 0) && ($urandom_range(0, 99) < 40);
      rdata      = $urandom;
      flush      = ($urandom_range(0, 99) < 7);
      if (waiting && data_ok && stale_q[0]) flush = 1'b0;
      if (waiting && !data_ok && stale_cnt >= MAXO) flush = 1'b0;
      exp_allowin = ~m_valid | (ready & ws_allowin);

      mid();
      chk("rnd.allowin", es_bus.ms_allowin, exp_allowin);
      chk("rnd.to_ws_valid", ms_to_ws_valid, ready);
      chk("rnd.pending", ms_fwd_pending, waiting & m_gr_we);
      chk("rnd.fwd_we", ms_fwd_we, m_valid & m_gr_we);
      if (m_valid) begin
        chk("rnd.dest", ms_dest, m_dest);
        chk("rnd.pc", ms_pc, m_pc);
      end
      if (ready) begin
        chk("rnd.result", ms_final_result, m_is_load ? m_data : m_result);
        chk("rnd.fwd_data", ms_fwd_data, m_is_load ? m_data : m_result);
      end

      popped_live = 1'b0;
      if (data_ok) begin
        front = stale_q.pop_front();
        if (!front) begin
          popped_live = 1'b1;
          if (!flush) begin
            m_have = 1'b1;
            m_data = ref_load(m_op, m_addr, rdata);
          end
        end
      end
      if (flush) begin
        if (waiting && !popped_live) stale_q[stale_q.size() - 1] = 1'b1;
        m_valid = 1'b0;
      end else begin
        if (ready && ws_allowin) m_valid = 1'b0;
        if (exp_allowin && r_valid) begin
          m_valid   = 1'b1;
          m_is_load = r_req;
          m_have    = 1'b0;
          m_gr_we   = r_we;
          m_dest    = r_d;
          m_op      = r_op;
          m_addr    = r_a;
          m_result  = r_res;
          m_pc      = r_pc;
          if (r_req) stale_q.push_back(1'b0);
        end
      end
      tick();
    end
    es_idle();
    flush   = 1'b0;
    data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
